axi_enhanced_rx_port_demux: RTL and testbench

Receive-side counterpart of the enhanced TX port mux. Takes the single AXI-Stream RX TLP stream from the PCIe block and routes each whole TLP to one of four downstream ports: request, completion, config and message. The port is chosen by decoding header DW0 on the first beat. Sits in axi_enhanced_top under axi_enhanced_rx, between the block RX pipeline and the bridge/config consumers. It also drops unsupported TLPs and flushes open packets on link down.

---
 rtl/axi_enhanced_rx_port_demux.sv | 137 +++++++++++++
 tb/tb_axi_enhanced_rx_port_demux.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_enhanced_rx_port_demux.sv
// axi_enhanced_rx_port_demux: routes each whole RX TLP to the req/cpl/cfg/msg port decoded from DW0,
// drops unsupported TLPs and sinks the rest of an open packet when the link goes down.
module axi_enhanced_rx_port_demux #(
  parameter int    C_DATA_WIDTH = 32,
  parameter string C_FAMILY     = "X7",
  parameter string C_ROOT_PORT  = "FALSE",
  parameter int    TCQ          = 1,
  parameter int    STRB_WIDTH   = C_DATA_WIDTH / 8
) (
  input  logic                    com_iclk,
  input  logic                    com_sysrst,
  input  logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
  input  logic [STRB_WIDTH-1:0]   m_axis_rx_tstrb,
  input  logic                    m_axis_rx_tlast,
  input  logic [21:0]             m_axis_rx_tuser,
  input  logic                    m_axis_rx_tvalid,
  output logic                    m_axis_rx_tready,
  output logic [C_DATA_WIDTH-1:0] s_axis_req_tdata,
  output logic [STRB_WIDTH-1:0]   s_axis_req_tstrb,
  output logic                    s_axis_req_tlast,
  output logic [21:0]             s_axis_req_tuser,
  output logic                    s_axis_req_tvalid,
  input  logic                    s_axis_req_tready,
  output logic [C_DATA_WIDTH-1:0] s_axis_cpl_tdata,
  output logic [STRB_WIDTH-1:0]   s_axis_cpl_tstrb,
  output logic                    s_axis_cpl_tlast,
  output logic [21:0]             s_axis_cpl_tuser,
  output logic                    s_axis_cpl_tvalid,
  input  logic                    s_axis_cpl_tready,
  output logic [C_DATA_WIDTH-1:0] s_axis_cfg_tdata,
  output logic [STRB_WIDTH-1:0]   s_axis_cfg_tstrb,
  output logic                    s_axis_cfg_tlast,
  output logic [21:0]             s_axis_cfg_tuser,
  output logic                    s_axis_cfg_tvalid,
  input  logic                    s_axis_cfg_tready,
  output logic [C_DATA_WIDTH-1:0] s_axis_msg_tdata,
  output logic [STRB_WIDTH-1:0]   s_axis_msg_tstrb,
  output logic                    s_axis_msg_tlast,
  output logic [21:0]             s_axis_msg_tuser,
  output logic                    s_axis_msg_tvalid,
  input  logic                    s_axis_msg_tready,
  input  logic                    trn_lnk_up,
  output logic                    rx_flush,
  output logic [7:0]              drop_cnt
);
  localparam bit ROOT = (C_ROOT_PORT == "TRUE");
  typedef enum logic [1:0] {IDLE, PKT, FLUSH} state_t;
  typedef enum logic [2:0] {CH_REQ, CH_CPL, CH_CFG, CH_MSG, CH_DROP} chan_t;
  state_t state, state_nxt;
  chan_t chan_q, dec_chan, cur_chan, out_chan;
  logic [C_DATA_WIDTH-1:0] out_data;
  logic [STRB_WIDTH-1:0] out_strb;
  logic [21:0] out_user;
  logic [4:0] ty;
  logic out_valid, out_last, rdy_en, lnk_d, sel_tready, acc, first, sink, lnk_down, tlast_acc;
  assign ty = m_axis_rx_tdata[28:24];
  always_comb begin
    dec_chan = (ty == 5'h00 || ty == 5'h01 || ty == 5'h02) ? CH_REQ :
               (ty == 5'h0A || ty == 5'h0B) ? CH_CPL :
               (ty == 5'h04 || ty == 5'h05) ? (ROOT ? CH_DROP : CH_CFG) :
               (ty[4:3] == 2'b10) ? CH_MSG : CH_DROP;
  end
  assign first      = state == IDLE;
  assign cur_chan   = first ? dec_chan : chan_q;
  assign sink       = state == FLUSH || cur_chan == CH_DROP;
  assign sel_tready = out_chan == CH_REQ ? s_axis_req_tready :
                      out_chan == CH_CPL ? s_axis_cpl_tready :
                      out_chan == CH_CFG ? s_axis_cfg_tready : s_axis_msg_tready;
  // rdy_en keeps ready low through reset and raises it on the first clock edge after
  assign m_axis_rx_tready = rdy_en & (sink | ~out_valid | sel_tready);
  assign acc       = m_axis_rx_tvalid & m_axis_rx_tready;
  assign tlast_acc = acc & m_axis_rx_tlast;
  assign lnk_down  = lnk_d & ~trn_lnk_up;
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = (acc && !m_axis_rx_tlast) ? PKT : IDLE;
    else if (tlast_acc)
      state_nxt = IDLE;
    else if (state == PKT && lnk_down)
      state_nxt = FLUSH;
  end
  always_ff @(posedge com_iclk or posedge com_sysrst)
    if (com_sysrst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge com_iclk or posedge com_sysrst) begin
    if (com_sysrst) begin
      rdy_en    <= 1'b0;
      lnk_d     <= 1'b0;
      rx_flush  <= 1'b0;
      drop_cnt  <= 8'd0;
      chan_q    <= CH_REQ;
      out_chan  <= CH_REQ;
      out_data  <= '0;
      out_strb  <= '0;
      out_user  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      lnk_d    <= trn_lnk_up;
      rx_flush <= state == PKT && state_nxt == FLUSH;
      if (acc && first) chan_q <= dec_chan;
      if (acc && first && dec_chan == CH_DROP && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (acc && !sink) begin
        out_data  <= m_axis_rx_tdata;
        out_strb  <= m_axis_rx_tstrb;
        out_user  <= m_axis_rx_tuser;
        out_last  <= m_axis_rx_tlast;
        out_chan  <= cur_chan;
        out_valid <= 1'b1;
      end else if (sel_tready) begin
        out_valid <= 1'b0;
      end
    end
  end
  assign s_axis_req_tvalid = out_valid && out_chan == CH_REQ;
  assign s_axis_cpl_tvalid = out_valid && out_chan == CH_CPL;
  assign s_axis_cfg_tvalid = out_valid && out_chan == CH_CFG;
  assign s_axis_msg_tvalid = out_valid && out_chan == CH_MSG;
  assign s_axis_req_tdata = out_data;
  assign s_axis_cpl_tdata = out_data;
  assign s_axis_cfg_tdata = out_data;
  assign s_axis_msg_tdata = out_data;
  assign s_axis_req_tstrb = out_strb;
  assign s_axis_cpl_tstrb = out_strb;
  assign s_axis_cfg_tstrb = out_strb;
  assign s_axis_msg_tstrb = out_strb;
  assign s_axis_req_tlast = out_last;
  assign s_axis_cpl_tlast = out_last;
  assign s_axis_cfg_tlast = out_last;
  assign s_axis_msg_tlast = out_last;
  assign s_axis_req_tuser = out_user;
  assign s_axis_cpl_tuser = out_user;
  assign s_axis_cfg_tuser = out_user;
  assign s_axis_msg_tuser = out_user;
endmodule

// File: tb/tb_axi_enhanced_rx_port_demux.sv
// tb_axi_enhanced_rx_port_demux: directed tests of routing, backpressure, drops, link-down flush and reset
module tb_axi_enhanced_rx_port_demux;
  localparam int DW = 64, SW = 8;
  logic clk = 0, rst = 1, lnk = 1;
  logic [DW-1:0] data = '0;
  logic [SW-1:0] strb = '1;
  logic last = 0, vld = 0, vld_rp = 0;
  logic [21:0] user = '0;
  logic req_rdy = 1, cpl_rdy = 1, cfg_rdy = 1, msg_rdy = 1;
  logic ready, flush, r_ready, r_flush;
  logic [7:0] drop, r_drop;
  logic [DW-1:0] d_req, d_cpl, d_cfg, d_msg, rd_req, rd_cpl, rd_cfg, rd_msg;
  logic [SW-1:0] s_req, s_cpl, s_cfg, s_msg, rs_req, rs_cpl, rs_cfg, rs_msg;
  logic l_req, l_cpl, l_cfg, l_msg, rl_req, rl_cpl, rl_cfg, rl_msg;
  logic [21:0] u_req, u_cpl, u_cfg, u_msg, ru_req, ru_cpl, ru_cfg, ru_msg;
  logic v_req, v_cpl, v_cfg, v_msg, rv_req, rv_cpl, rv_cfg, rv_msg;
  logic [3:0] pv, rpv;
  int total = 0, bad = 0;
  assign pv  = {v_msg, v_cfg, v_cpl, v_req};
  assign rpv = {rv_msg, rv_cfg, rv_cpl, rv_req};
  always #5 clk = ~clk;

  axi_enhanced_rx_port_demux #(.C_DATA_WIDTH(DW), .C_ROOT_PORT("FALSE")) dut (
    .com_iclk(clk), .com_sysrst(rst),
    .m_axis_rx_tdata(data), .m_axis_rx_tstrb(strb), .m_axis_rx_tlast(last), .m_axis_rx_tuser(user),
    .m_axis_rx_tvalid(vld), .m_axis_rx_tready(ready),
    .s_axis_req_tdata(d_req), .s_axis_req_tstrb(s_req), .s_axis_req_tlast(l_req), .s_axis_req_tuser(u_req),
    .s_axis_req_tvalid(v_req), .s_axis_req_tready(req_rdy),
    .s_axis_cpl_tdata(d_cpl), .s_axis_cpl_tstrb(s_cpl), .s_axis_cpl_tlast(l_cpl), .s_axis_cpl_tuser(u_cpl),
    .s_axis_cpl_tvalid(v_cpl), .s_axis_cpl_tready(cpl_rdy),
    .s_axis_cfg_tdata(d_cfg), .s_axis_cfg_tstrb(s_cfg), .s_axis_cfg_tlast(l_cfg), .s_axis_cfg_tuser(u_cfg),
    .s_axis_cfg_tvalid(v_cfg), .s_axis_cfg_tready(cfg_rdy),
    .s_axis_msg_tdata(d_msg), .s_axis_msg_tstrb(s_msg), .s_axis_msg_tlast(l_msg), .s_axis_msg_tuser(u_msg),
    .s_axis_msg_tvalid(v_msg), .s_axis_msg_tready(msg_rdy),
    .trn_lnk_up(lnk), .rx_flush(flush), .drop_cnt(drop)
  );

  axi_enhanced_rx_port_demux #(.C_DATA_WIDTH(DW), .C_ROOT_PORT("TRUE")) dut_rp (
    .com_iclk(clk), .com_sysrst(rst),
    .m_axis_rx_tdata(data), .m_axis_rx_tstrb(strb), .m_axis_rx_tlast(last), .m_axis_rx_tuser(user),
    .m_axis_rx_tvalid(vld_rp), .m_axis_rx_tready(r_ready),
    .s_axis_req_tdata(rd_req), .s_axis_req_tstrb(rs_req), .s_axis_req_tlast(rl_req), .s_axis_req_tuser(ru_req),
    .s_axis_req_tvalid(rv_req), .s_axis_req_tready(req_rdy),
    .s_axis_cpl_tdata(rd_cpl), .s_axis_cpl_tstrb(rs_cpl), .s_axis_cpl_tlast(rl_cpl), .s_axis_cpl_tuser(ru_cpl),
    .s_axis_cpl_tvalid(rv_cpl), .s_axis_cpl_tready(cpl_rdy),
    .s_axis_cfg_tdata(rd_cfg), .s_axis_cfg_tstrb(rs_cfg), .s_axis_cfg_tlast(rl_cfg), .s_axis_cfg_tuser(ru_cfg),
    .s_axis_cfg_tvalid(rv_cfg), .s_axis_cfg_tready(cfg_rdy),
    .s_axis_msg_tdata(rd_msg), .s_axis_msg_tstrb(rs_msg), .s_axis_msg_tlast(rl_msg), .s_axis_msg_tuser(ru_msg),
    .s_axis_msg_tvalid(rv_msg), .s_axis_msg_tready(msg_rdy),
    .trn_lnk_up(lnk), .rx_flush(r_flush), .drop_cnt(r_drop)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (pv !== 4'b0) begin bad++; $display("FAIL reset_valids got=%b exp=0000", pv); end
    total++; if (drop !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
    step; step;
    rst = 0;
    step; #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", ready); end
    total++; if (r_ready !== 1'b1) begin bad++; $display("FAIL post_reset_rp_ready got=%b exp=1", r_ready); end
  endtask

  task automatic test_mwr;
    logic [63:0] b [3];
    b[0] = 64'hA0A0_0000_4000_0001; b[1] = 64'h1111_2222_3333_4444; b[2] = 64'h5555_6666_7777_8888;
    user = 22'h2ABCD;
    for (int i = 0; i < 5; i++) begin
      step;
      vld = i < 3; data = i < 3 ? b[i] : '0; last = i == 2;
      #1;
      if (i < 3) begin
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL mwr_ready%0d got=%b exp=1", i, ready); end
      end
      if (i == 0 || i == 4) begin
        total++; if (pv !== 4'b0) begin bad++; $display("FAIL mwr_idle%0d got=%b exp=0000", i, pv); end
      end else begin
        total++; if (pv !== 4'b0001) begin bad++; $display("FAIL mwr_valid%0d got=%b exp=0001", i, pv); end
        total++; if (d_req !== b[i-1]) begin bad++; $display("FAIL mwr_data%0d got=%h exp=%h", i, d_req, b[i-1]); end
        total++; if (l_req !== (i == 3)) begin bad++; $display("FAIL mwr_last%0d got=%b exp=%b", i, l_req, i == 3); end
      end
    end
    total++; if (u_req !== 22'h2ABCD) begin bad++; $display("FAIL mwr_user got=%h exp=2abcd", u_req); end
    user = '0;
  endtask

  task automatic test_cpl_stall;
    logic [63:0] b [2];
    b[0] = 64'h1234_5678_4A00_0001; b[1] = 64'h9ABC_DEF0_0F0F_0F0F;
    for (int c = 0; c < 7; c++) begin
      step;
      cpl_rdy = c >= 4; vld = c <= 4; data = c == 0 ? b[0] : b[1]; last = c != 0;
      #1;
      if (c <= 4) begin
        total++; if (ready !== (c == 0 || c == 4)) begin bad++; $display("FAIL cpl_ready%0d got=%b exp=%b", c, ready, c == 0 || c == 4); end
      end
      total++; if (pv !== ((c == 0 || c == 6) ? 4'b0 : 4'b0010)) begin bad++; $display("FAIL cpl_valid%0d got=%b", c, pv); end
      if (c >= 1 && c <= 5) begin
        total++; if (d_cpl !== b[c == 5]) begin bad++; $display("FAIL cpl_data%0d got=%h exp=%h", c, d_cpl, b[c == 5]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] dw [3];
    logic [3:0] ep [3];
    dw[0] = 32'h0000_0001; dw[1] = 32'h3400_0000; dw[2] = 32'h0400_0001;
    ep[0] = 4'b0001; ep[1] = 4'b1000; ep[2] = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      step;
      vld = c < 3; last = 1; data = c < 3 ? {28'hC0DE000, c[3:0], dw[c]} : '0;
      #1;
      if (c < 3) begin
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", c, ready); end
      end
      if (c >= 1 && c <= 3) begin
        total++; if (pv !== ep[c-1]) begin bad++; $display("FAIL b2b_valid%0d got=%b exp=%b", c, pv, ep[c-1]); end
        total++; if (d_req[31:0] !== dw[c-1]) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", c, d_req[31:0], dw[c-1]); end
      end
      if (c == 4) begin
        total++; if (pv !== 4'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0000", pv); end
      end
    end
    last = 0;
  endtask

  task automatic test_drop;
    step;
    req_rdy = 0; vld = 1; data = 64'h0000_0000_0000_0001; last = 1;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL drop_mrd_ready got=%b exp=1", ready); end
    step;
    data = 64'hFFFF_0000_1F00_0000; last = 0;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL drop_b0_ready got=%b exp=1", ready); end
    total++; if (pv !== 4'b0001) begin bad++; $display("FAIL drop_hold got=%b exp=0001", pv); end
    total++; if (drop !== 8'd0) begin bad++; $display("FAIL drop_cnt0 got=%0d exp=0", drop); end
    step;
    last = 1;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL drop_b1_ready got=%b exp=1", ready); end
    total++; if (drop !== 8'd1) begin bad++; $display("FAIL drop_cnt1 got=%0d exp=1", drop); end
    step;
    vld = 0; req_rdy = 1; last = 0;
    #1;
    total++; if (pv !== 4'b0001 || d_req !== 64'h1) begin bad++; $display("FAIL drop_mrd_out got=%b/%h exp=0001/1", pv, d_req); end
    step; #1;
    total++; if (pv !== 4'b0) begin bad++; $display("FAIL drop_idle got=%b exp=0000", pv); end
    total++; if (drop !== 8'd1) begin bad++; $display("FAIL drop_cnt_final got=%0d exp=1", drop); end
  endtask

  task automatic test_root_port;
    step;
    vld_rp = 1; data = 64'h0000_0000_0400_0001; last = 1;
    #1;
    total++; if (r_ready !== 1'b1) begin bad++; $display("FAIL rp_ready got=%b exp=1", r_ready); end
    step;
    data = 64'h0000_0000_1F00_0000;
    #1;
    total++; if (rpv !== 4'b0 || r_drop !== 8'd1) begin bad++; $display("FAIL rp_cfg_drop got=%b/%0d exp=0000/1", rpv, r_drop); end
    step;
    vld_rp = 0;
    #1;
    total++; if (rpv !== 4'b0 || r_drop !== 8'd2) begin bad++; $display("FAIL rp_two_drops got=%b/%0d exp=0000/2", rpv, r_drop); end
    for (int i = 0; i < 300; i++) begin
      step;
      vld_rp = 1; data = 64'h0000_0000_1F00_0000; last = 1;
    end
    step;
    vld_rp = 0; last = 0;
    #1;
    total++; if (r_drop !== 8'd255) begin bad++; $display("FAIL rp_saturate got=%0d exp=255", r_drop); end
    total++; if (rpv !== 4'b0) begin bad++; $display("FAIL rp_no_valid got=%b exp=0000", rpv); end
  endtask

  task automatic test_link_down;
    logic [63:0] b [5];
    b[0] = 64'h0101_0101_4000_0001; b[1] = 64'h0202_0202_0202_0202; b[2] = 64'h0303_0303_0303_0303;
    b[3] = 64'h0404_0404_0404_0404; b[4] = 64'h0505_0505_0505_0505;
    for (int c = 0; c < 7; c++) begin
      step;
      lnk = c == 0; vld = c < 5; data = c < 5 ? b[c] : '0; last = c == 4;
      #1;
      if (c < 5) begin
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL lnk_ready%0d got=%b exp=1", c, ready); end
      end
      total++; if (flush !== (c == 2)) begin bad++; $display("FAIL lnk_flush%0d got=%b exp=%b", c, flush, c == 2); end
      if (c == 1 || c == 2) begin
        total++; if (pv !== 4'b0001 || d_req !== b[c-1]) begin bad++; $display("FAIL lnk_out%0d got=%b/%h exp=0001/%h", c, pv, d_req, b[c-1]); end
      end
      if (c >= 3) begin
        total++; if (pv !== 4'b0) begin bad++; $display("FAIL lnk_sunk%0d got=%b exp=0000", c, pv); end
      end
    end
    step;
    lnk = 1; last = 0;
    step;
    vld = 1; data = 64'h0000_0000_0000_0001; last = 1;
    step;
    vld = 0; last = 0;
    #1;
    total++; if (pv !== 4'b0001 || d_req !== 64'h1) begin bad++; $display("FAIL lnk_next_pkt got=%b/%h exp=0001/1", pv, d_req); end
  endtask

  task automatic test_link_down_tlast;
    step;
    vld = 1; data = 64'h0000_0000_4000_0001; last = 0;
    step;
    data = 64'h7777_7777_7777_7777; last = 1; lnk = 0;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL lt_ready got=%b exp=1", ready); end
    step;
    vld = 0; last = 0;
    #1;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL lt_flush got=%b exp=0", flush); end
    total++; if (pv !== 4'b0001 || l_req !== 1'b1) begin bad++; $display("FAIL lt_last got=%b/%b exp=0001/1", pv, l_req); end
    step;
    lnk = 1;
    step;
  endtask

  task automatic test_reset_mid;
    step;
    vld = 1; data = 64'h0000_0000_4000_0001; last = 0;
    step;
    data = 64'h8888_8888_8888_8888;
    step;
    data = 64'h9999_9999_9999_9999;
    rst = 1;
    #1;
    total++; if (pv !== 4'b0) begin bad++; $display("FAIL rst_mid_valids got=%b exp=0000", pv); end
    total++; if (drop !== 8'd0 || r_drop !== 8'd0) begin bad++; $display("FAIL rst_mid_drop got=%0d/%0d exp=0/0", drop, r_drop); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b exp=0", ready); end
    step;
    rst = 0; vld = 0;
    step;
    vld = 1; data = 64'h0000_0000_4A00_0001; last = 1;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_fresh_ready got=%b exp=1", ready); end
    step;
    vld = 0; last = 0;
    #1;
    total++; if (pv !== 4'b0010 || d_cpl !== 64'h4A00_0001) begin bad++; $display("FAIL rst_fresh_cpl got=%b/%h exp=0010/4a000001", pv, d_cpl); end
  endtask

  initial begin
    test_reset;
    test_mwr;
    test_cpl_stall;
    test_back_to_back;
    test_drop;
    test_root_port;
    test_link_down;
    test_link_down_tlast;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
